// File: rtl/fifo_drain_serializer.sv
// Purpose     : drains a DATA_W-bit FIFO one word at a time and serialises each word into BYTE_W-bit beats.
// Latency     : beat 0 appears 2 cycles after the pop pulse; one word per NBYTES+2 cycles when out_ready stays high.
// Backpressure: out_ready low freezes out_data/out_last; no new pop is issued until the current word's last beat is accepted.
//
// Ports:
//   clk, reset      - rising-edge clock; asynchronous active-low reset
//   fifo_empty      - upstream FIFO empty flag (looked at only while idle)
//   fifo_out        - FIFO read data, valid the cycle after pop was sampled
//   pop             - one-cycle pop request
//   out_data        - current beat
//   out_valid       - beat valid
//   out_ready       - downstream accepts the beat
//   out_last        - final beat of a word
//   busy            - engine is not idle
//   word_count      - words fully transmitted, wraps
//
// Build option: define SER_MSB_FIRST_EN to send the most-significant byte first
// (default is least-significant byte first). Ports and timing are unchanged.
module fifo_drain_serializer #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              pop,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    generate
        if ((DATA_W % BYTE_W) != 0 || NBYTES < 1) begin : g_bad_width
            $error("fifo_drain_serializer: DATA_W must be a non-zero multiple of BYTE_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] shreg;
    logic              load;
    logic              word_done;
    logic [IDX_W-1:0]  sel;

    // Beat order only changes which byte lane a given beat index selects.
`ifdef SER_MSB_FIRST_EN
    assign sel = LAST_IDX - idx;
`else
    assign sel = idx;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            shreg      <= '0;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                shreg <= fifo_out;
            end
            if (word_done) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        load      = 1'b0;
        word_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Qualified with reset so no word is popped (and lost) while
                // the engine is held in reset with a non-empty FIFO.
                pop = !fifo_empty && reset;
                if (!fifo_empty) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // fifo_out carries the popped word during this cycle.
                load      = 1'b1;
                idx_nxt   = '0;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = shreg[sel*BYTE_W +: BYTE_W];
                out_last  = (idx == LAST_IDX);
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        word_done = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
- Downstream consumer of the 32-bit `fifo` block.
- Pops one word at a time whenever the FIFO is non-empty.
- Splits each word into BYTE_W-bit beats and sends them on a valid/ready byte stream toward the output interface.
- Keeps a running count of words fully transmitted, for debug and performance monitoring.

Parameters:
- DATA_W, 32: FIFO word width. Must be an integer multiple of BYTE_W; elaboration-time error otherwise.
- BYTE_W, 8: width of one output beat.
- CNT_W, 16: width of word_count.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronised to the clk rising edge.
- fifo_empty  input  1  FIFO empty flag.
- fifo_out  input  DATA_W  FIFO read data. Valid in the cycle after the edge that sampled pop=1.
- pop  output  1  FIFO pop request, one-cycle pulse.
- out_data  output  BYTE_W  current output beat.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both 1 at a rising edge.
- out_last  output  1  marks the final beat of a word.
- busy  output  1  high in any state other than IDLE.
- word_count  output  CNT_W  number of words fully transmitted; wraps modulo 2^CNT_W.

Behaviour:
- NBYTES = DATA_W/BYTE_W; byte index idx has width clog2(NBYTES), minimum 1.
- Reset values: pop=0, out_data=0, out_valid=0, out_last=0, busy=0, word_count=0, state=IDLE, idx=0, shift register=0.
- FSM states: IDLE, CAPTURE, SEND.
- IDLE:
  - pop = !fifo_empty (combinational from state and fifo_empty).
  - If !fifo_empty, go to CAPTURE at the next edge; otherwise stay in IDLE.
  - out_valid=0.
- CAPTURE:
  - pop=0.
  - At the edge: shift register <= fifo_out, idx <= 0, go to SEND.
- SEND:
  - out_valid=1.
  - out_data = byte idx of the shift register; byte 0 = bits [BYTE_W-1:0] (LSB first).
  - out_last = (idx == NBYTES-1).
  - On handshake with idx < NBYTES-1: idx++, stay in SEND.
  - On handshake with idx == NBYTES-1: word_count++ (wraps), go to IDLE.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- pop never asserts while fifo_empty=1 and never asserts outside IDLE, so there is no underflow and at most one word is in flight.
- fifo_empty is ignored in CAPTURE and SEND.
- Throughput with out_ready held at 1: one word per NBYTES+2 cycles. Pop pulses are spaced 6 cycles apart for the default parameters.
- Reset mid-word: the partial word is discarded and word_count is cleared. After release, the block restarts in IDLE, and the next word begins at byte 0.
- out_ready toggling while out_valid=0 has no effect.

Optional Feature:
- Macro: SER_MSB_FIRST_EN.
- Defined: beats are sent most-significant byte first. Beat k = bits [DATA_W-1-k*BYTE_W -: BYTE_W]. out_last still marks beat NBYTES-1, which then carries bits [BYTE_W-1:0].
- Undefined (default): LSB first, as described in Behaviour.
- Ports, timing and word_count are identical in both builds.

Test Plan:
- FIFO model holds 0x11223344, out_ready=1 → pop pulses once; 2 cycles later beats 0x44, 0x33, 0x22, 0x11 appear on consecutive cycles, with out_last=1 only on 0x11; word_count=1; busy returns to 0.
- Same word, out_ready=0 for 3 cycles while beat 0x33 is presented → out_data holds 0x33 and out_valid holds 1 for all 3 cycles; the sequence then resumes with 0x22 and 0x11; no extra pop.
- fifo_empty=1 for 20 cycles after reset → pop, out_valid and busy stay 0 throughout; word_count=0.
- Push words 1, 2, 3 into the FIFO, out_ready=1 → 12 beats: 01,00,00,00, 02,00,00,00, 03,00,00,00; out_last on beats 4, 8 and 12; pop pulses 6 cycles apart; final word_count=3.
- Assert reset during beat 2 of 0xAABBCCDD → outputs go to 0 asynchronously with no clock edge needed. After release with 0x01020304 next in the FIFO, the first beat is 0x04; word_count counts from 0.
- SER_MSB_FIRST_EN defined, word 0x11223344 → beats 0x11, 0x22, 0x33, 0x44, with out_last on 0x44.
